// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, word width
// and the queue entry layout.
package fetcher_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } q_entry_t;

endpackage

// File: rtl/fetcher_inst_queue.sv
// In-order instruction queue: circular buffer of {pc, inst} with clear,
// simultaneous push/pop, occupancy count and a combinational head entry.
module inst_queue
  import fetcher_pkg::*;
#(
  parameter int LOG = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic           clear_i,
  input  q_entry_t       data_i,
  output q_entry_t       head_o,
  output logic [LOG:0]   count_o
);

  localparam int DEPTH = 1 << LOG;

  q_entry_t           mem_q [DEPTH];
  logic [LOG-1:0]     head_q;
  logic [LOG-1:0]     tail_q;
  logic [LOG:0]       count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally at the power-of-two depth.
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: owns the fetch PC, the memory request FSM and the
// issue rule that reserves a queue slot for every outstanding request.
//
// state         | meaning
// FETCH_IDLE    | no request outstanding; issue when a slot is guaranteed
// FETCH_REQ     | request outstanding, its data will be queued
// FETCH_DISCARD | request outstanding after a flush, its data is dropped
module fetcher
  import fetcher_pkg::*;
#(
  parameter int                QUEUE_LOG = 3,
  parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [WORD_W-1:0] flush_pc_in,
  output logic              mem_req_out,
  output logic [WORD_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [WORD_W-1:0] mem_data_in,
  output logic              flag_IF,
  output logic [WORD_W-1:0] inst_IF,
  output logic [WORD_W-1:0] pc_IF
);

  localparam int                 DEPTH   = 1 << QUEUE_LOG;
  localparam logic [QUEUE_LOG+1:0] DEPTH_W = (QUEUE_LOG + 2)'(DEPTH);

  fetch_state_e       state_q;
  logic [WORD_W-1:0]  pc_q;
  logic               req_q;
  logic [WORD_W-1:0]  addr_q;

  logic [QUEUE_LOG:0]   count;
  logic [QUEUE_LOG+1:0] occ_d;
  q_entry_t             head;
  q_entry_t             wdata;
  logic                 pop;
  logic                 push;
  logic                 clear;
  logic                 issue_ok;

  assign flag_IF = rdy_in & ~stall_in & ~flush_in & (count != '0);
  assign pop     = flag_IF;
  assign push    = rdy_in & ~flush_in & mem_ack_in & (state_q == FETCH_REQ);
  assign clear   = rdy_in & flush_in;
  assign wdata   = {addr_q, mem_data_in};

  // Occupancy after this cycle's pop/push; below DEPTH leaves room for one more.
  always_comb begin
    occ_d = {1'b0, count};
    if (push) occ_d = occ_d + 1'b1;
    if (pop)  occ_d = occ_d - 1'b1;
    issue_ok = (occ_d < DEPTH_W);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc_q <= flush_pc_in;
        if (state_q == FETCH_REQ) begin
          if (mem_ack_in) begin
            req_q   <= 1'b0;
            state_q <= FETCH_IDLE;
          end else begin
            state_q <= FETCH_DISCARD;
          end
        end
      end else begin
        case (state_q)
          FETCH_IDLE: begin
            if (issue_ok) begin
              req_q   <= 1'b1;
              addr_q  <= pc_q;
              state_q <= FETCH_REQ;
            end
          end
          FETCH_REQ: begin
            if (mem_ack_in) begin
              pc_q <= pc_q + 32'd4;
              if (issue_ok) begin
                addr_q <= pc_q + 32'd4;
              end else begin
                req_q   <= 1'b0;
                state_q <= FETCH_IDLE;
              end
            end
          end
          FETCH_DISCARD: begin
            if (mem_ack_in) begin
              req_q   <= 1'b0;
              state_q <= FETCH_IDLE;
            end
          end
          default: begin
            req_q   <= 1'b0;
            state_q <= FETCH_IDLE;
          end
        endcase
      end
    end
  end

  inst_queue #(.LOG(QUEUE_LOG)) u_queue (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .data_i  (wdata),
    .head_o  (head),
    .count_o (count)
  );

  assign mem_req_out  = req_q;
  assign mem_addr_out = addr_q;
  assign inst_IF      = head.inst;
  assign pc_IF        = head.pc;

endmodule
